memory_arbiter: RTL and testbench

//  Round-robin arbiter sharing one single-port on-chip RAM (8192x32, byte enables, 1-cycle read latency) among N Avalon-MM masters.

---
 rtl/memarb_pkg.sv | 22 ++
 rtl/memarb_rr_pick.sv | 26 ++
 rtl/memory_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_memory_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/memarb_pkg.sv
// Shared types and constants for the round-robin RAM arbiter.
// The lock feature is enabled by defining MEMARB_LOCK_EN.
package memarb_pkg;

  localparam int unsigned MAX_MASTERS = 4;
  localparam int unsigned IDX_W       = $clog2(MAX_MASTERS);
  localparam int unsigned ADDR_W_DEF  = 13;
  localparam int unsigned DATA_W_DEF  = 32;

  typedef enum logic {
    ARB_OPEN,
    ARB_LOCKED
  } arb_state_t;

  // (idx + 1) mod n, for n not necessarily a power of two
  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx,
                                                 input int unsigned      n);
    if (32'(idx) + 32'd1 >= n) return '0;
    return idx + IDX_W'(1);
  endfunction

endpackage

// File: rtl/memarb_rr_pick.sv
// Rotating-priority encoder: picks the first asserted request at or after ptr, modulo N.
module memarb_rr_pick
  import memarb_pkg::*;
#(
  parameter int unsigned N = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic             grant_vld,
  output logic [IDX_W-1:0] grant_idx
);

  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int k = 0; k < N; k++) begin
      for (int i = 0; i < N; i++) begin
        if (!grant_vld && req[i] && ((32'(ptr) + k) % N) == i) begin
          grant_vld = 1'b1;
          grant_idx = IDX_W'(i);
        end
      end
    end
  end

endmodule

// File: rtl/memory_arbiter.sv
// Round-robin arbiter sharing one single-port 1-cycle-latency RAM among N Avalon-MM masters.
// Optional bus locking is compiled in when MEMARB_LOCK_EN is defined.
module memory_arbiter
  import memarb_pkg::*;
#(
  parameter int unsigned NUM_MASTERS = 2,
  parameter int unsigned ADDR_W      = ADDR_W_DEF,
  parameter int unsigned DATA_W      = DATA_W_DEF,
  parameter int unsigned LOCK_MAX    = 16
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic [NUM_MASTERS*ADDR_W-1:0]   m_address,
  input  logic [NUM_MASTERS*DATA_W/8-1:0] m_byteenable,
  input  logic [NUM_MASTERS-1:0]          m_read,
  input  logic [NUM_MASTERS-1:0]          m_write,
  input  logic [NUM_MASTERS*DATA_W-1:0]   m_writedata,
  input  logic [NUM_MASTERS-1:0]          m_lock,
  output logic [NUM_MASTERS-1:0]          m_waitrequest,
  output logic [NUM_MASTERS-1:0]          m_readdatavalid,
  output logic [DATA_W-1:0]               m_readdata,
  output logic [ADDR_W-1:0]               mem_address,
  output logic [DATA_W/8-1:0]             mem_byteenable,
  output logic                            mem_chipselect,
  output logic                            mem_write,
  output logic [DATA_W-1:0]               mem_writedata,
  input  logic [DATA_W-1:0]               mem_readdata
);

  localparam int unsigned N    = NUM_MASTERS;
  localparam int unsigned BE_W = DATA_W / 8;

  logic [N-1:0]     req;
  logic [N-1:0]     req_masked;
  logic             pick_vld;
  logic [IDX_W-1:0] pick_idx;
  logic             grant_vld;
  logic [IDX_W-1:0] grant_idx;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic             rd_pend_q;
  logic [IDX_W-1:0] rd_owner_q;

  assign req = m_read | m_write;

  memarb_rr_pick #(
    .N (N)
  ) u_rr_pick (
    .req       (req_masked),
    .ptr       (rr_ptr_q),
    .grant_vld (pick_vld),
    .grant_idx (pick_idx)
  );

  // Nothing is granted while reset is held, even though the pointer is already cleared
  assign grant_vld = pick_vld & reset_n;
  assign grant_idx = pick_idx;

  always_comb begin
    m_waitrequest  = '1;
    mem_chipselect = 1'b0;
    mem_write      = 1'b0;
    mem_address    = '0;
    mem_byteenable = '0;
    mem_writedata  = '0;
    for (int i = 0; i < N; i++) begin
      if (grant_vld && grant_idx == IDX_W'(i)) begin
        m_waitrequest[i] = 1'b0;
        mem_chipselect   = 1'b1;
        mem_write        = m_write[i];
        mem_address      = m_address[i*ADDR_W +: ADDR_W];
        mem_byteenable   = m_byteenable[i*BE_W +: BE_W];
        mem_writedata    = m_writedata[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    m_readdatavalid = '0;
    m_readdata      = '0;
    if (rd_pend_q) begin
      m_readdata = mem_readdata;
      for (int i = 0; i < N; i++) begin
        if (rd_owner_q == IDX_W'(i)) m_readdatavalid[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr_q   <= '0;
      rd_pend_q  <= 1'b0;
      rd_owner_q <= '0;
    end else begin
      rr_ptr_q  <= rr_ptr_d;
      rd_pend_q <= grant_vld & ~mem_write;
      if (grant_vld && !mem_write) rd_owner_q <= grant_idx;
    end
  end

`ifdef MEMARB_LOCK_EN
  localparam int unsigned CNT_W = $clog2(LOCK_MAX + 1);

  arb_state_t       state_q, state_d;
  logic [IDX_W-1:0] lock_owner_q, lock_owner_d;
  logic [CNT_W-1:0] lock_cnt_q, lock_cnt_d;
  logic             no_relock_q, no_relock_d;
  logic             gnt_lock;

  always_comb begin
    req_masked = req;
    if (state_q == ARB_LOCKED) begin
      req_masked = '0;
      for (int i = 0; i < N; i++) begin
        if (lock_owner_q == IDX_W'(i)) req_masked[i] = req[i];
      end
    end
  end

  always_comb begin
    gnt_lock = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (grant_idx == IDX_W'(i)) gnt_lock = m_lock[i];
    end
  end

  always_comb begin
    state_d      = state_q;
    lock_owner_d = lock_owner_q;
    lock_cnt_d   = lock_cnt_q;
    no_relock_d  = no_relock_q;
    rr_ptr_d     = grant_vld ? next_idx(grant_idx, N) : rr_ptr_q;
    // A forced-release owner regains relock rights after an idle cycle or a foreign grant
    if (!grant_vld || grant_idx != lock_owner_q) no_relock_d = 1'b0;
    unique case (state_q)
      ARB_OPEN: begin
        if (grant_vld && gnt_lock && !(no_relock_q && grant_idx == lock_owner_q)) begin
          lock_owner_d = grant_idx;
          lock_cnt_d   = CNT_W'(1);
          if (LOCK_MAX <= 1) no_relock_d = 1'b1;
          else               state_d     = ARB_LOCKED;
        end
      end
      ARB_LOCKED: begin
        if (!grant_vld || !gnt_lock) begin
          state_d    = ARB_OPEN;
          lock_cnt_d = '0;
          rr_ptr_d   = next_idx(lock_owner_q, N);
        end else if (32'(lock_cnt_q) + 32'd1 >= LOCK_MAX) begin
          state_d     = ARB_OPEN;
          lock_cnt_d  = '0;
          no_relock_d = 1'b1;
        end else begin
          lock_cnt_d = lock_cnt_q + CNT_W'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ARB_OPEN;
      lock_owner_q <= '0;
      lock_cnt_q   <= '0;
      no_relock_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      lock_owner_q <= lock_owner_d;
      lock_cnt_q   <= lock_cnt_d;
      no_relock_q  <= no_relock_d;
    end
  end
`else
  localparam int unsigned unused_lock_max = LOCK_MAX;
  logic unused_lock;

  assign unused_lock = ^m_lock;
  assign req_masked  = req;
  assign rr_ptr_d    = grant_vld ? next_idx(grant_idx, N) : rr_ptr_q;
`endif

endmodule

// File: tb/tb_memory_arbiter.sv
// Scoreboard bench for memory_arbiter: directed scenarios plus randomized traffic vs a reference model.
module tb_memory_arbiter;

  localparam int NM      = 2;
  localparam int AW      = 13;
  localparam int DW      = 32;
  localparam int BW      = DW / 8;
  localparam int LOCKMAX = 4;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [NM*AW-1:0]  m_address;
  logic [NM*BW-1:0]  m_byteenable;
  logic [NM-1:0]     m_read, m_write, m_lock;
  logic [NM*DW-1:0]  m_writedata;
  logic [NM-1:0]     m_waitrequest, m_readdatavalid;
  logic [DW-1:0]     m_readdata;
  logic [AW-1:0]     mem_address;
  logic [BW-1:0]     mem_byteenable;
  logic              mem_chipselect, mem_write;
  logic [DW-1:0]     mem_writedata;
  logic [DW-1:0]     mem_readdata;

  memory_arbiter #(
    .NUM_MASTERS (NM),
    .ADDR_W      (AW),
    .DATA_W      (DW),
    .LOCK_MAX    (LOCKMAX)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .m_address       (m_address),
    .m_byteenable    (m_byteenable),
    .m_read          (m_read),
    .m_write         (m_write),
    .m_writedata     (m_writedata),
    .m_lock          (m_lock),
    .m_waitrequest   (m_waitrequest),
    .m_readdatavalid (m_readdatavalid),
    .m_readdata      (m_readdata),
    .mem_address     (mem_address),
    .mem_byteenable  (mem_byteenable),
    .mem_chipselect  (mem_chipselect),
    .mem_write       (mem_write),
    .mem_writedata   (mem_writedata),
    .mem_readdata    (mem_readdata)
  );

  always #5 clk = ~clk;

  // Per-master stimulus, packed onto the DUT buses
  logic          t_rd[NM], t_wr[NM], t_lk[NM];
  logic [AW-1:0] t_addr[NM];
  logic [BW-1:0] t_be[NM];
  logic [DW-1:0] t_wd[NM];

  always_comb begin
    for (int i = 0; i < NM; i++) begin
      m_read[i]                 = t_rd[i];
      m_write[i]                = t_wr[i];
      m_lock[i]                 = t_lk[i];
      m_address[i*AW +: AW]     = t_addr[i];
      m_byteenable[i*BW +: BW]  = t_be[i];
      m_writedata[i*DW +: DW]   = t_wd[i];
    end
  end

  // Single-port RAM with byte enables and 1-cycle read latency
  logic [DW-1:0] ram[8192];
  always @(posedge clk) begin
    if (mem_chipselect) begin
      if (mem_write) begin
        for (int b = 0; b < BW; b++)
          if (mem_byteenable[b]) ram[mem_address][b*8 +: 8] <= mem_writedata[b*8 +: 8];
      end else begin
        mem_readdata <= ram[mem_address];
      end
    end
  end

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Reference model state
  typedef struct {
    int            owner;
    logic [DW-1:0] data;
    int            due;
  } rd_t;

  rd_t           exp_q[$];
  logic [DW-1:0] ref_mem[8192];
  int            mdl_ptr;
  int            glog[$];
  bit            mdl_locked, mdl_block;
  int            mdl_owner, mdl_cnt;

  always @(negedge reset_n) begin
    exp_q.delete();
    mdl_ptr    = 0;
    mdl_locked = 0;
    mdl_block  = 0;
    mdl_owner  = 0;
    mdl_cnt    = 0;
  end

  function automatic int rr_pick(input int ptr);
    for (int k = 0; k < NM; k++) begin
      int j;
      j = (ptr + k) % NM;
      if (t_rd[j] || t_wr[j]) return j;
    end
    return -1;
  endfunction

  // Predictor: decides the expected grant and checks the issue side every cycle
  always @(negedge clk) begin
    int            g, act_g;
    logic [NM-1:0] exp_wait;
    if (!reset_n) begin
      chk("rst_waitreq", 64'(m_waitrequest), 64'({NM{1'b1}}));
      chk("rst_cs", 64'(mem_chipselect), 64'd0);
      chk("rst_mwrite", 64'(mem_write), 64'd0);
      chk("rst_rdv", 64'(m_readdatavalid), 64'd0);
    end else begin
`ifdef MEMARB_LOCK_EN
      if (mdl_locked) begin
        g = (t_rd[mdl_owner] || t_wr[mdl_owner]) ? mdl_owner : -1;
        mdl_ptr = (mdl_owner + 1) % NM;
        if (g < 0 || !t_lk[g]) mdl_locked = 0;
        else begin
          mdl_cnt++;
          if (mdl_cnt >= LOCKMAX) begin
            mdl_locked = 0;
            mdl_block  = 1;
          end
        end
      end else begin
        g = rr_pick(mdl_ptr);
        if (g != mdl_owner) mdl_block = 0;
        if (g >= 0) begin
          mdl_ptr = (g + 1) % NM;
          if (t_lk[g] && !(mdl_block && g == mdl_owner)) begin
            mdl_owner  = g;
            mdl_cnt    = 1;
            mdl_locked = 1;
          end
        end
      end
`else
      g = rr_pick(mdl_ptr);
      if (g >= 0) mdl_ptr = (g + 1) % NM;
`endif
      exp_wait = '1;
      if (g >= 0) exp_wait[g] = 1'b0;
      chk("waitreq", 64'(m_waitrequest), 64'(exp_wait));
      chk("chipsel", 64'(mem_chipselect), 64'(g >= 0));
      act_g = -1;
      for (int i = 0; i < NM; i++) if (!m_waitrequest[i]) act_g = i;
      if (act_g >= 0) glog.push_back(act_g);
      if (g >= 0) begin
        chk("mem_addr", 64'(mem_address), 64'(t_addr[g]));
        chk("mem_be", 64'(mem_byteenable), 64'(t_be[g]));
        chk("mem_wdata", 64'(mem_writedata), 64'(t_wd[g]));
        chk("mem_write", 64'(mem_write), 64'(t_wr[g]));
        if (t_wr[g]) begin
          for (int b = 0; b < BW; b++)
            if (t_be[g][b]) ref_mem[t_addr[g]][b*8 +: 8] = t_wd[g][b*8 +: 8];
        end else begin
          exp_q.push_back('{owner: g, data: ref_mem[t_addr[g]], due: cyc + 1});
        end
      end else begin
        chk("idle_bus", 64'({mem_write, mem_address, mem_byteenable, mem_writedata}), 64'd0);
      end
    end
  end

  // Monitor: pops the scoreboard whenever read data is presented or due
  always @(negedge clk) begin
    if (reset_n) begin
      if (m_readdatavalid != '0 || (exp_q.size() > 0 && exp_q[0].due == cyc)) begin
        if (exp_q.size() == 0) begin
          chk("rdv_spurious", 64'(m_readdatavalid), 64'd0);
        end else begin
          rd_t e;
          e = exp_q.pop_front();
          chk("rdv_owner", 64'(m_readdatavalid), 64'(1 << e.owner));
          chk("rd_latency", 64'(cyc), 64'(e.due));
          chk("rdata", 64'(m_readdata), 64'(e.data));
        end
      end else begin
        chk("rdata_idle", 64'(m_readdata), 64'd0);
      end
    end
  end

  task automatic idle_all();
    for (int i = 0; i < NM; i++) begin
      t_rd[i] = 0; t_wr[i] = 0; t_lk[i] = 0;
      t_addr[i] = '0; t_be[i] = '0; t_wd[i] = '0;
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    reset_n = 1'b0;
    idle_all();
    for (int i = 0; i < 8192; i++) begin
      logic [DW-1:0] v;
      v = $urandom;
      ram[i] <= v;
      ref_mem[i] = v;
    end

    // Reset holds everyone off even with requests pending; master 0 wins first after release
    t_rd[0] = 1; t_rd[1] = 1;
    t_addr[0] = 13'h10; t_addr[1] = 13'h20;
    step(3);
    glog.delete();
    reset_n = 1'b1;
    step(8);
    chk("alt_g0", 64'(glog[0]), 64'd0);
    chk("alt_g1", 64'(glog[1]), 64'd1);
    chk("alt_g2", 64'(glog[2]), 64'd0);
    chk("alt_g3", 64'(glog[3]), 64'd1);

    // Partial write then read of the same word the next cycle
    idle_all();
    t_wr[0] = 1; t_addr[0] = 13'h5; t_wd[0] = 32'hDEADBEEF; t_be[0] = 4'b0011;
    step(1);
    idle_all();
    t_rd[1] = 1; t_addr[1] = 13'h5;
    step(1);
    idle_all();
    step(2);

    // Reset while a read is in flight: the read is dropped
    t_rd[1] = 1; t_addr[1] = 13'h7;
    step(1);
    idle_all();
    reset_n = 1'b0;
    step(1);
    reset_n = 1'b1;
    step(2);

    // Long idle, then contention must still start at master 0
    step(10);
    glog.delete();
    t_rd[0] = 1; t_rd[1] = 1; t_addr[0] = 13'h30; t_addr[1] = 13'h31;
    step(4);
    chk("post_idle_g0", 64'(glog[0]), 64'd0);
    idle_all();
    step(2);

`ifdef MEMARB_LOCK_EN
    glog.delete();
    t_rd[0] = 1; t_lk[0] = 1; t_addr[0] = 13'h40;
    t_rd[1] = 1; t_addr[1] = 13'h41;
    step(6);
    for (int i = 0; i < 4; i++) chk("lock_owner_run", 64'(glog[i]), 64'd0);
    chk("lock_release", 64'(glog[4]), 64'd1);
    idle_all();
    step(2);
`endif

    // Randomized traffic over a small address window to provoke read-after-write hazards
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < NM; i++) begin
        int p;
        p = $urandom_range(0, 99);
        t_rd[i]   = (p < 45) || (p >= 90);
        t_wr[i]   = (p >= 45 && p < 70) || (p >= 90);
        t_lk[i]   = ($urandom_range(0, 3) == 0);
        t_addr[i] = AW'($urandom_range(0, 15));
        t_be[i]   = BW'($urandom);
        t_wd[i]   = $urandom;
      end
      if (c == 300) reset_n = 1'b0;
      if (c == 302) reset_n = 1'b1;
      step(1);
    end
    idle_all();
    step(3);
    chk("drain", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
